// File: rtl/lbus_pkg.sv
// Shared definitions for the local-bus responder: register addresses,
// CTRL bit positions, FSM state encoding and an address-block helper.
package lbus_pkg;

    localparam logic [15:0] ADDR_CTRL      = 16'h0002;
    localparam logic [15:0] ADDR_MODE      = 16'h000C;
    localparam logic [15:0] ADDR_KEY_BASE  = 16'h0100;
    localparam logic [15:0] ADDR_TIN_BASE  = 16'h0140;
    localparam logic [15:0] ADDR_TOUT_BASE = 16'h0180;

    localparam int CTRL_KSET_BIT  = 1;
    localparam int CTRL_START_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KSET = 2'd1,
        ENC  = 2'd2
    } state_t;

    // True when the address lies in the 16-byte window starting at base.
    function automatic logic in_block(input logic [15:0] a, input logic [15:0] base);
        return a[15:4] == base[15:4];
    endfunction

endpackage

// File: rtl/lbus_strobe_sync.sv
// Registers the local-bus inputs once and edge-detects the strobes, so each
// strobe assertion yields exactly one wr_pulse / rd_pulse aligned with the
// registered address and write data.
module lbus_strobe_sync (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] lbus_a,
    input  logic [15:0] lbus_dw,
    input  logic        lbus_wr,
    input  logic        lbus_rd,
    output logic        wr_pulse,
    output logic        rd_pulse,
    output logic [15:0] addr,
    output logic [15:0] wdata
);

    logic wr_q, wr_qq, rd_q, rd_qq;

    // Input stage q plus the qq stage used for rising-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr  <= 16'h0000;
            wdata <= 16'h0000;
            wr_q  <= 1'b0;
            wr_qq <= 1'b0;
            rd_q  <= 1'b0;
            rd_qq <= 1'b0;
        end else begin
            addr  <= lbus_a;
            wdata <= lbus_dw;
            wr_q  <= lbus_wr;
            wr_qq <= wr_q;
            rd_q  <= lbus_rd;
            rd_qq <= rd_q;
        end
    end

    assign wr_pulse = wr_q & ~wr_qq;
    assign rd_pulse = rd_q & ~rd_qq;

endmodule

// File: rtl/lbus_responder.sv
// Local-bus responder: decodes controller writes into KEY/TEXT_IN/MODE/CTRL,
// serves register reads, and sequences key-set and encryption handshakes
// with the cipher core. exec is high for the whole of each encryption.
// Build option: LBUS_KEY_READBACK_EN makes KEY words readable.
module lbus_responder
    import lbus_pkg::*;
#(
    parameter int BLK_W = 128
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [15:0]      lbus_a,
    input  logic [15:0]      lbus_dw,
    input  logic             lbus_wr,
    input  logic             lbus_rd,
    output logic [15:0]      lbus_dr,
    output logic             exec,
    output logic [BLK_W-1:0] blk_kin,
    output logic [BLK_W-1:0] blk_din,
    output logic             blk_encdec,
    output logic             blk_krdy,
    output logic             blk_drdy,
    input  logic             blk_kvld,
    input  logic             blk_dvld,
    input  logic [BLK_W-1:0] blk_dout
);

    localparam int NW = BLK_W / 16;

    logic        wr_pulse, rd_pulse;
    logic [15:0] addr, wdata;
    logic [2:0]  idx;
    logic        word_ok;
    logic [15:0] rd_data;
    state_t      state;

    logic [15:0] key_w  [NW];
    logic [15:0] din_w  [NW];
    logic [15:0] tout_w [NW];

    lbus_strobe_sync u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .lbus_a   (lbus_a),
        .lbus_dw  (lbus_dw),
        .lbus_wr  (lbus_wr),
        .lbus_rd  (lbus_rd),
        .wr_pulse (wr_pulse),
        .rd_pulse (rd_pulse),
        .addr     (addr),
        .wdata    (wdata)
    );

    assign idx     = addr[3:1];
    assign word_ok = int'(idx) < NW;

    // Word 0 is the most significant word of each block.
    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_words
            assign blk_kin[BLK_W-1-16*gi -: 16] = key_w[gi];
            assign blk_din[BLK_W-1-16*gi -: 16] = din_w[gi];
        end
    endgenerate

    // Handshake FSM; krdy/drdy are one-cycle pulses, exec spans ENC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            blk_krdy <= 1'b0;
            blk_drdy <= 1'b0;
            exec     <= 1'b0;
        end else begin
            blk_krdy <= 1'b0;
            blk_drdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_pulse && addr == ADDR_CTRL) begin
                        if (wdata[CTRL_KSET_BIT]) begin
                            state    <= KSET;
                            blk_krdy <= 1'b1;
                        end else if (wdata[CTRL_START_BIT]) begin
                            state    <= ENC;
                            blk_drdy <= 1'b1;
                            exec     <= 1'b1;
                        end
                    end
                end
                KSET: begin
                    if (blk_kvld) state <= IDLE;
                end
                ENC: begin
                    if (blk_dvld) begin
                        state <= IDLE;
                        exec  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register writes (accepted only in IDLE) and result capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_encdec <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                key_w[i]  <= 16'h0000;
                din_w[i]  <= 16'h0000;
                tout_w[i] <= 16'h0000;
            end
        end else begin
            if (wr_pulse && state == IDLE) begin
                if (addr == ADDR_MODE)
                    blk_encdec <= wdata[0];
                if (in_block(addr, ADDR_KEY_BASE) && word_ok)
                    key_w[idx] <= wdata;
                if (in_block(addr, ADDR_TIN_BASE) && word_ok)
                    din_w[idx] <= wdata;
            end
            if (state == ENC && blk_dvld) begin
                for (int i = 0; i < NW; i++)
                    tout_w[i] <= blk_dout[BLK_W-1-16*i -: 16];
            end
        end
    end

    // Read-data mux; unmapped addresses read as zero.
    always_comb begin
        rd_data = 16'h0000;
        if (addr == ADDR_CTRL)
            rd_data = {14'b0, state == KSET, state == ENC};
        else if (addr == ADDR_MODE)
            rd_data = {15'b0, blk_encdec};
        else if (in_block(addr, ADDR_TIN_BASE) && word_ok)
            rd_data = din_w[idx];
        else if (in_block(addr, ADDR_TOUT_BASE) && word_ok)
            rd_data = tout_w[idx];
`ifdef LBUS_KEY_READBACK_EN
        else if (in_block(addr, ADDR_KEY_BASE) && word_ok)
            rd_data = key_w[idx];
`endif
    end

    // Read data register; a coincident write edge takes precedence.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            lbus_dr <= 16'h0000;
        else if (rd_pulse && !wr_pulse)
            lbus_dr <= rd_data;
    end

endmodule

// File: tb/tb_lbus_responder.sv
// Directed testbench for lbus_responder with a small cipher-core stand-in.
module tb_lbus_responder;

    localparam int BLK_W = 128;
    localparam logic [127:0] KEY_VAL = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] TIN_VAL = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] TOUT_VAL = 128'h3925841d02dc09fbdc118597196a0b32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [15:0]      lbus_a = 16'h0;
    logic [15:0]      lbus_dw = 16'h0;
    logic             lbus_wr = 1'b0;
    logic             lbus_rd = 1'b0;
    logic [15:0]      lbus_dr;
    logic             exec;
    logic [BLK_W-1:0] blk_kin, blk_din, blk_dout;
    logic             blk_encdec, blk_krdy, blk_drdy;
    logic             blk_kvld = 1'b0;
    logic             blk_dvld;
    logic             dvld_auto = 1'b0, dvld_man = 1'b0;
    logic [BLK_W-1:0] dout_auto = '0, dout_man = '0;
    logic             core_auto = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int krdy_cnt = 0, drdy_cnt = 0, exec_cnt = 0;
    int drdy0, exec0, krdy0;
    logic krdy_at, drdy_at, exec_at;
    logic [15:0] rd_val;
    logic [15:0] key_rb_exp;

    assign blk_dvld = dvld_auto | dvld_man;
    assign blk_dout = dvld_auto ? dout_auto : dout_man;

    lbus_responder #(.BLK_W(BLK_W)) dut (
        .clk(clk), .rstn(rstn),
        .lbus_a(lbus_a), .lbus_dw(lbus_dw), .lbus_wr(lbus_wr), .lbus_rd(lbus_rd),
        .lbus_dr(lbus_dr), .exec(exec),
        .blk_kin(blk_kin), .blk_din(blk_din), .blk_encdec(blk_encdec),
        .blk_krdy(blk_krdy), .blk_drdy(blk_drdy),
        .blk_kvld(blk_kvld), .blk_dvld(blk_dvld), .blk_dout(blk_dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (blk_krdy) krdy_cnt++;
        if (blk_drdy) drdy_cnt++;
        if (exec)     exec_cnt++;
    end

    // Core stand-in: result valid is sampled on the 10th edge after drdy.
    always begin
        @(negedge clk);
        if (blk_drdy && core_auto) begin
            repeat (9) @(negedge clk);
            dout_auto = TOUT_VAL;
            dvld_auto = 1'b1;
            @(negedge clk);
            dvld_auto = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        lbus_a = a; lbus_dw = d; lbus_wr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        krdy_at = blk_krdy; drdy_at = blk_drdy; exec_at = exec;
        @(negedge clk);
        lbus_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [15:0] a);
        @(negedge clk);
        lbus_a = a; lbus_rd = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rd_val = lbus_dr;
        @(negedge clk);
        lbus_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_kvld();
        @(negedge clk);
        blk_kvld = 1'b1;
        @(negedge clk);
        blk_kvld = 1'b0;
    endtask

    initial begin
        logic [127:0] kv, tv;
        kv = KEY_VAL;
        tv = TIN_VAL;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_lbus_dr", {112'b0, lbus_dr}, 128'h0);
        check_eq("rst_kin", blk_kin, 128'h0);
        check_eq("rst_din", blk_din, 128'h0);
        check_eq("rst_ctl", {124'b0, blk_encdec, blk_krdy, blk_drdy, exec}, 128'h0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Key load and key set
        for (int i = 0; i < 8; i++)
            bus_write(16'h0100 + 16'(2*i), kv[127-16*i -: 16]);
        check_eq("key_kin", blk_kin, KEY_VAL);
        krdy0 = krdy_cnt;
        bus_write(16'h0002, 16'h0002);
        check_eq("kset_krdy_timing", {127'b0, krdy_at}, 128'h1);
        check_eq("kset_krdy_once", 128'(krdy_cnt - krdy0), 128'd1);
        bus_read(16'h0002);
        check_eq("kset_busy_rd", {112'b0, rd_val}, 128'h0002);
        pulse_kvld();
        bus_read(16'h0002);
        check_eq("kset_done_rd", {112'b0, rd_val}, 128'h0000);

        // Mode write
        bus_write(16'h000C, 16'h0001);
        check_eq("mode_set", {127'b0, blk_encdec}, 128'h1);
        bus_write(16'h000C, 16'h0000);
        check_eq("mode_clr", {127'b0, blk_encdec}, 128'h0);

        // Encryption
        for (int i = 0; i < 8; i++)
            bus_write(16'h0140 + 16'(2*i), tv[127-16*i -: 16]);
        check_eq("tin_din", blk_din, TIN_VAL);
        core_auto = 1'b1;
        drdy0 = drdy_cnt;
        exec0 = exec_cnt;
        bus_write(16'h0002, 16'h0001);
        check_eq("enc_drdy_exec_timing", {126'b0, drdy_at, exec_at}, 128'h3);
        for (int i = 0; i < 50 && exec; i++) @(negedge clk);
        check_eq("enc_done", {127'b0, exec}, 128'h0);
        check_eq("enc_exec_cycles", 128'(exec_cnt - exec0), 128'd10);
        check_eq("enc_drdy_once", 128'(drdy_cnt - drdy0), 128'd1);
        core_auto = 1'b0;
        bus_read(16'h0180);
        check_eq("tout_w0", {112'b0, rd_val}, 128'h3925);
        bus_read(16'h018E);
        check_eq("tout_w7", {112'b0, rd_val}, 128'h0b32);

        // Simultaneous write and read edges: write wins, lbus_dr holds
        @(negedge clk);
        lbus_a = 16'h000C; lbus_dw = 16'h0001; lbus_wr = 1'b1; lbus_rd = 1'b1;
        repeat (2) @(negedge clk);
        lbus_wr = 1'b0; lbus_rd = 1'b0;
        @(negedge clk);
        check_eq("wr_rd_mode", {127'b0, blk_encdec}, 128'h1);
        check_eq("wr_rd_dr_hold", {112'b0, lbus_dr}, 128'h0b32);
        bus_write(16'h000C, 16'h0000);

        // Key readback and unmapped read
`ifdef LBUS_KEY_READBACK_EN
        key_rb_exp = 16'h2B7E;
`else
        key_rb_exp = 16'h0000;
`endif
        bus_read(16'h0100);
        check_eq("key_readback", {112'b0, rd_val}, {112'b0, key_rb_exp});
        bus_read(16'h0180);
        bus_read(16'h0500);
        check_eq("unmapped_rd", {112'b0, rd_val}, 128'h0);

        // CTRL = 3: only key set
        krdy0 = krdy_cnt;
        drdy0 = drdy_cnt;
        bus_write(16'h0002, 16'h0003);
        check_eq("both_krdy", {127'b0, krdy_at}, 128'h1);
        check_eq("both_no_drdy_exec", {126'b0, drdy_at, exec}, 128'h0);
        check_eq("both_drdy_cnt", 128'(drdy_cnt - drdy0), 128'd0);
        check_eq("both_krdy_cnt", 128'(krdy_cnt - krdy0), 128'd1);
        pulse_kvld();

        // Writes ignored during ENC
        drdy0 = drdy_cnt;
        bus_write(16'h0002, 16'h0001);
        check_eq("enc2_exec", {127'b0, exec}, 128'h1);
        bus_write(16'h0140, 16'hFFFF);
        check_eq("enc2_din_kept", blk_din, TIN_VAL);
        bus_write(16'h0002, 16'h0001);
        check_eq("enc2_single_drdy", 128'(drdy_cnt - drdy0), 128'd1);
        bus_read(16'h0002);
        check_eq("enc2_busy_rd", {112'b0, rd_val}, 128'h0001);

        // Reset mid-encryption, then a stale dvld
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_eq("arst_exec", {127'b0, exec}, 128'h0);
        check_eq("arst_regs", blk_kin | blk_din, 128'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        dout_man = {128{1'b1}};
        dvld_man = 1'b1;
        @(negedge clk);
        dvld_man = 1'b0;
        @(negedge clk);
        check_eq("stale_dvld_exec", {127'b0, exec}, 128'h0);
        bus_read(16'h0180);
        check_eq("stale_dvld_tout", {112'b0, rd_val}, 128'h0);
        bus_read(16'h0002);
        check_eq("stale_dvld_idle", {112'b0, rd_val}, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
